// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit with private HI/LO and a multi-cycle busy period.
// Define MDU_MADD_EN to enable the madd/maddu/msub/msubu accumulate operations (codes 9-12).
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_rs_val,
  input  logic [31:0] E_rt_val,
  input  logic [3:0]  E_mdu_op,
  input  logic        req,
  output logic        E_mdu_busy,
  output logic [31:0] E_mdu_rd,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,  OP_MULT  = 4'd1,  OP_MULTU = 4'd2,  OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,  OP_MFHI  = 4'd5,  OP_MFLO  = 4'd6,  OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,  OP_MADD  = 4'd9,  OP_MADDU = 4'd10, OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } mdu_op_e;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  logic is_mul, is_div, is_mac, mac_sub, sgn, start;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_mac  = 1'b0;
    mac_sub = 1'b0;
    sgn     = 1'b0;
    case (E_mdu_op)
      OP_MULT:  begin is_mul = 1'b1; sgn = 1'b1; end
      OP_MULTU: is_mul = 1'b1;
      OP_DIV:   begin is_div = 1'b1; sgn = 1'b1; end
      OP_DIVU:  is_div = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:  begin is_mac = 1'b1; sgn = 1'b1; end
      OP_MADDU: is_mac = 1'b1;
      OP_MSUB:  begin is_mac = 1'b1; sgn = 1'b1; mac_sub = 1'b1; end
      OP_MSUBU: begin is_mac = 1'b1; mac_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  // Signed and unsigned multiplies share one multiplier: only the operand extension differs.
  logic [63:0] rs_ext, rt_ext, prod, acc, mac_res;
  assign rs_ext  = sgn ? {{32{E_rs_val[31]}}, E_rs_val} : {32'b0, E_rs_val};
  assign rt_ext  = sgn ? {{32{E_rt_val[31]}}, E_rt_val} : {32'b0, E_rt_val};
  assign prod    = rs_ext * rt_ext;
  assign acc     = {hi_q, lo_q};
  assign mac_res = mac_sub ? (acc - prod) : (acc + prod);

  // Signed division on magnitudes: quotient truncates toward zero, remainder follows the dividend.
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, q_mag, r_mag, quot, rem;
  assign neg_a = sgn & E_rs_val[31];
  assign neg_b = sgn & E_rt_val[31];
  assign mag_a = neg_a ? (~E_rs_val + 32'd1) : E_rs_val;
  assign mag_b = neg_b ? (~E_rt_val + 32'd1) : E_rt_val;
  assign q_mag = mag_a / mag_b;
  assign r_mag = mag_a % mag_b;
  assign quot  = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
  assign rem   = neg_a ? (~r_mag + 32'd1) : r_mag;

  // Gating with reset keeps busy low while reset is held, even with a mult op sitting in E.
  assign start      = reset && (state_q == S_IDLE) && !req && (is_mul || is_div || is_mac);
  assign E_mdu_busy = start || (state_q == S_BUSY);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_BUSY;
          cnt_d   = is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
          if (is_div) begin
            // A zero divisor still runs the full busy period but writes back the old HI/LO.
            if (E_rt_val == 32'd0) {pend_hi_d, pend_lo_d} = acc;
            else                   {pend_hi_d, pend_lo_d} = {rem, quot};
          end else if (is_mac) begin
            {pend_hi_d, pend_lo_d} = mac_res;
          end else begin
            {pend_hi_d, pend_lo_d} = prod;
          end
        end else if (!req && E_mdu_op == OP_MTHI) begin
          hi_d = E_rs_val;
        end else if (!req && E_mdu_op == OP_MTLO) begin
          lo_d = E_rs_val;
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  always_comb begin
    E_mdu_rd = '0;
    if (E_mdu_op == OP_MFHI)      E_mdu_rd = hi_q;
    else if (E_mdu_op == OP_MFLO) E_mdu_rd = lo_q;
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: self-checking bench for e_mdu; directed scenarios plus randomized ops against a
// behavioural HI/LO model built on 64-bit integer arithmetic.
module tb_e_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] E_rs_val, E_rt_val;
  logic [3:0]  E_mdu_op;
  logic        req;
  logic        E_mdu_busy;
  logic [31:0] E_mdu_rd, HI, LO;

  int total = 0;
  int bad   = 0;

  logic [31:0] hi_m, lo_m;

  e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk        (clk),
    .reset      (reset),
    .E_rs_val   (E_rs_val),
    .E_rt_val   (E_rt_val),
    .E_mdu_op   (E_mdu_op),
    .req        (req),
    .E_mdu_busy (E_mdu_busy),
    .E_mdu_rd   (E_mdu_rd),
    .HI         (HI),
    .LO         (LO)
  );

  always #5 clk = ~clk;

  // Reference model: applies one instruction to hi_m/lo_m and reports the expected busy length.
  task automatic model_exec(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                            input bit rq, output int exp_busy);
    longint      a, b, q, r;
    logic [63:0] p, accv;
    exp_busy = 0;
    if (!rq) begin
      case (op)
        4'd1: begin
          p = longint'($signed(rs)) * longint'($signed(rt));
          {hi_m, lo_m} = p;
          exp_busy = MULT_N + 1;
        end
        4'd2: begin
          p = {32'b0, rs} * {32'b0, rt};
          {hi_m, lo_m} = p;
          exp_busy = MULT_N + 1;
        end
        4'd3: begin
          exp_busy = DIV_N + 1;
          if (rt != 32'd0) begin
            a = longint'($signed(rs));
            b = longint'($signed(rt));
            q = a / b;
            r = a % b;
            lo_m = q[31:0];
            hi_m = r[31:0];
          end
        end
        4'd4: begin
          exp_busy = DIV_N + 1;
          if (rt != 32'd0) begin
            lo_m = rs / rt;
            hi_m = rs % rt;
          end
        end
        4'd7: hi_m = rs;
        4'd8: lo_m = rs;
`ifdef MDU_MADD_EN
        4'd9, 4'd10, 4'd11, 4'd12: begin
          if (op == 4'd9 || op == 4'd11) p = longint'($signed(rs)) * longint'($signed(rt));
          else                           p = {32'b0, rs} * {32'b0, rt};
          accv = {hi_m, lo_m};
          {hi_m, lo_m} = (op >= 4'd11) ? accv - p : accv + p;
          exp_busy = MULT_N + 1;
        end
`endif
        default: ;
      endcase
    end
  endtask

  // Presents one op for one cycle (starting at a negedge) and measures how long busy stays high.
  task automatic mdu_exec(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input bit rq, output int busy_cycles, output logic [31:0] rd0,
                          output bit timeout);
    E_mdu_op = op;
    E_rs_val = rs;
    E_rt_val = rt;
    req      = rq;
    timeout  = 1'b0;
    #1;
    rd0         = E_mdu_rd;
    busy_cycles = E_mdu_busy ? 1 : 0;
    @(posedge clk);
    #1;
    E_mdu_op = 4'd0;
    req      = 1'b0;
    forever begin
      @(negedge clk);
      if (!E_mdu_busy) break;
      busy_cycles++;
      if (busy_cycles > 64) begin
        timeout = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    req      = 1'b0;
    E_mdu_op = 4'd1;
    E_rs_val = 32'd5;
    E_rt_val = 32'd7;
    repeat (2) @(negedge clk);
    total++;
    if (E_mdu_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", E_mdu_busy); end
    total++;
    if (HI !== 32'd0 || LO !== 32'd0) begin
      bad++; $display("FAIL reset_hilo got=%h_%h want=0_0", HI, LO);
    end
    E_mdu_op = 4'd6;
    #1;
    total++;
    if (E_mdu_rd !== 32'd0) begin bad++; $display("FAIL reset_rd got=%h want=0", E_mdu_rd); end
    @(negedge clk);
    E_mdu_op = 4'd0;
    reset    = 1'b1;
    hi_m     = '0;
    lo_m     = '0;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int          bc, eb;
    logic [31:0] rd;
    bit          to;
    model_exec(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, eb);
    mdu_exec(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, bc, rd, to);
    total++;
    if (to || bc != 6) begin bad++; $display("FAIL mult_busy got=%0d timeout=%0b want=6", bc, to); end
    total++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
      bad++; $display("FAIL mult_result got=%h_%h want=ffffffff_fffffffa", HI, LO);
    end
    model_exec(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, eb);
    mdu_exec(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, bc, rd, to);
    total++;
    if (HI !== 32'hFFFF_FFFE || LO !== 32'h0000_0001 || bc != eb) begin
      bad++; $display("FAIL multu_max got=%h_%h busy=%0d want=fffffffe_00000001 busy=%0d", HI, LO, bc, eb);
    end
  endtask

  task automatic test_div();
    int          bc, eb;
    logic [31:0] rd;
    bit          to;
    model_exec(4'd4, 32'd7, 32'd2, 1'b0, eb);
    mdu_exec(4'd4, 32'd7, 32'd2, 1'b0, bc, rd, to);
    total++;
    if (to || bc != DIV_N + 1) begin bad++; $display("FAIL divu_busy got=%0d want=%0d", bc, DIV_N + 1); end
    total++;
    if (LO !== 32'd3 || HI !== 32'd1) begin bad++; $display("FAIL divu_result got=%h_%h want=1_3", HI, LO); end
    model_exec(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, eb);
    mdu_exec(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, bc, rd, to);
    total++;
    if (LO !== 32'hFFFF_FFFD || HI !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL div_neg got=%h_%h want=ffffffff_fffffffd", HI, LO);
    end
    model_exec(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, eb);
    mdu_exec(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, bc, rd, to);
    total++;
    if (LO !== 32'h8000_0000 || HI !== 32'd0) begin
      bad++; $display("FAIL div_overflow got=%h_%h want=00000000_80000000", HI, LO);
    end
    model_exec(4'd7, 32'h11, 32'd0, 1'b0, eb);
    mdu_exec(4'd7, 32'h11, 32'd0, 1'b0, bc, rd, to);
    model_exec(4'd8, 32'h22, 32'd0, 1'b0, eb);
    mdu_exec(4'd8, 32'h22, 32'd0, 1'b0, bc, rd, to);
    total++;
    if (bc != 0 || HI !== 32'h11 || LO !== 32'h22) begin
      bad++; $display("FAIL mthi_mtlo got=%h_%h busy=%0d want=11_22 busy=0", HI, LO, bc);
    end
    model_exec(4'd3, 32'd99, 32'd0, 1'b0, eb);
    mdu_exec(4'd3, 32'd99, 32'd0, 1'b0, bc, rd, to);
    total++;
    if (to || bc != DIV_N + 1 || HI !== 32'h11 || LO !== 32'h22) begin
      bad++; $display("FAIL div_zero got=%h_%h busy=%0d want=11_22 busy=%0d", HI, LO, bc, DIV_N + 1);
    end
  endtask

  task automatic test_req();
    int          bc;
    logic [31:0] rd;
    bit          to;
    mdu_exec(4'd1, 32'd9, 32'd9, 1'b1, bc, rd, to);
    total++;
    if (bc != 0 || HI !== hi_m || LO !== lo_m) begin
      bad++; $display("FAIL req_mult got=%h_%h busy=%0d want=%h_%h busy=0", HI, LO, bc, hi_m, lo_m);
    end
    mdu_exec(4'd7, 32'hDEAD_BEEF, 32'd0, 1'b1, bc, rd, to);
    total++;
    if (HI !== hi_m) begin bad++; $display("FAIL req_mthi got=%h want=%h", HI, hi_m); end
  endtask

  // Ops appearing in E while BUSY: mflo reads the old LO, mthi is ignored.
  task automatic test_busy_ops();
    int          bc, eb, n;
    logic [31:0] rd;
    bit          to;
    model_exec(4'd8, 32'h55, 32'd0, 1'b0, eb);
    mdu_exec(4'd8, 32'h55, 32'd0, 1'b0, bc, rd, to);
    model_exec(4'd1, 32'd2, 32'd3, 1'b0, eb);
    E_mdu_op = 4'd1; E_rs_val = 32'd2; E_rt_val = 32'd3; req = 1'b0;
    @(posedge clk); #1;
    E_mdu_op = 4'd6;
    @(negedge clk);
    total++;
    if (E_mdu_rd !== 32'h55 || E_mdu_busy !== 1'b1) begin
      bad++; $display("FAIL mflo_busy got=%h busy=%b want=55 busy=1", E_mdu_rd, E_mdu_busy);
    end
    E_mdu_op = 4'd7; E_rs_val = 32'hDEAD_0000;
    @(negedge clk);
    E_mdu_op = 4'd0;
    n = 0;
    while (E_mdu_busy && n < 64) begin @(negedge clk); n++; end
    total++;
    if (n >= 64 || HI !== hi_m || LO !== lo_m) begin
      bad++; $display("FAIL busy_ignore got=%h_%h want=%h_%h", HI, LO, hi_m, lo_m);
    end
  endtask

  task automatic test_mid_reset();
    int          bc, eb;
    logic [31:0] rd;
    bit          to;
    model_exec(4'd7, 32'h77, 32'd0, 1'b0, eb);
    mdu_exec(4'd7, 32'h77, 32'd0, 1'b0, bc, rd, to);
    E_mdu_op = 4'd3; E_rs_val = 32'd100; E_rt_val = 32'd7; req = 1'b0;
    @(posedge clk); #1;
    E_mdu_op = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (E_mdu_busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      bad++; $display("FAIL midreset got=%h_%h busy=%b want=0_0 busy=0", HI, LO, E_mdu_busy);
    end
    @(negedge clk);
    reset = 1'b1;
    hi_m  = '0;
    lo_m  = '0;
    repeat (12) @(negedge clk);
    total++;
    if (E_mdu_busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      bad++; $display("FAIL midreset_abort got=%h_%h busy=%b want=0_0 busy=0", HI, LO, E_mdu_busy);
    end
    mdu_exec(4'd5, 32'd0, 32'd0, 1'b0, bc, rd, to);
    total++;
    if (rd !== 32'd0) begin bad++; $display("FAIL midreset_mfhi got=%h want=0", rd); end
  endtask

  task automatic test_madd();
    int          bc, eb;
    logic [31:0] rd;
    bit          to;
    model_exec(4'd7, 32'd0, 32'd0, 1'b0, eb);
    mdu_exec(4'd7, 32'd0, 32'd0, 1'b0, bc, rd, to);
    model_exec(4'd8, 32'hFFFF_FFFF, 32'd0, 1'b0, eb);
    mdu_exec(4'd8, 32'hFFFF_FFFF, 32'd0, 1'b0, bc, rd, to);
    model_exec(4'd9, 32'd1, 32'd1, 1'b0, eb);
    mdu_exec(4'd9, 32'd1, 32'd1, 1'b0, bc, rd, to);
`ifdef MDU_MADD_EN
    total++;
    if (to || bc != MULT_N + 1 || HI !== 32'd1 || LO !== 32'd0) begin
      bad++; $display("FAIL madd got=%h_%h busy=%0d want=1_0 busy=%0d", HI, LO, bc, MULT_N + 1);
    end
`else
    total++;
    if (bc != 0 || HI !== 32'd0 || LO !== 32'hFFFF_FFFF) begin
      bad++; $display("FAIL madd_off got=%h_%h busy=%0d want=0_ffffffff busy=0", HI, LO, bc);
    end
`endif
    model_exec(4'd11, 32'hFFFF_FFFF, 32'd3, 1'b0, eb);
    mdu_exec(4'd11, 32'hFFFF_FFFF, 32'd3, 1'b0, bc, rd, to);
    total++;
    if (bc != eb || HI !== hi_m || LO !== lo_m) begin
      bad++; $display("FAIL msub got=%h_%h busy=%0d want=%h_%h busy=%0d", HI, LO, bc, hi_m, lo_m, eb);
    end
  endtask

  // Back-to-back random ops: each new op is presented in the first cycle after busy drops.
  task automatic test_random();
    logic [3:0]  ops [13] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                              4'd9, 4'd10, 4'd11, 4'd12, 4'd0};
    logic [31:0] corner [4] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd1};
    logic [3:0]  op;
    logic [31:0] rs, rt, rd, exp_rd;
    int          bc, eb;
    bit          rq, to;
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 12)];
      rs = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      rt = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      rq = ($urandom_range(0, 7) == 0);
      exp_rd = (op == 4'd5) ? hi_m : (op == 4'd6) ? lo_m : 32'd0;
      model_exec(op, rs, rt, rq, eb);
      mdu_exec(op, rs, rt, rq, bc, rd, to);
      total++;
      if (to || bc != eb || rd !== exp_rd || HI !== hi_m || LO !== lo_m) begin
        bad++;
        $display("FAIL rand%0d op=%0d rs=%h rt=%h req=%0b got=%h_%h busy=%0d rd=%h want=%h_%h busy=%0d rd=%h",
                 i, op, rs, rt, rq, HI, LO, bc, rd, hi_m, lo_m, eb, exp_rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_req();
    test_busy_ops();
    test_mid_reset();
    test_madd();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit. Consumes the operands and decoded MDU operation held in the D→E pipeline register, runs multi-cycle mult/div operations against private HI/LO registers, and returns HI/LO for mfhi/mflo in the same cycle. Its busy indication drives the hazard unit, which stalls MDU instructions in D. An exception request suppresses any MDU side effect of the instruction currently in E.

## Interface
- MULT_CYCLES, 5: busy cycles for mult/multu (and madd family); must be ≥1.
- DIV_CYCLES, 10: busy cycles for div/divu; must be ≥1.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low (0 = reset asserted).
- E_rs_val  in  32  forwarded rs operand.
- E_rt_val  in  32  forwarded rt operand.
- E_mdu_op  in  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu, 11 msub, 12 msubu. Codes 13–15 are treated as none.
- req  in  1  exception/interrupt flush; the E instruction must not affect MDU state.
- E_mdu_busy  out  1  start condition present OR state BUSY.
- E_mdu_rd  out  32  HI for mfhi, LO for mflo, else 0.
- HI  out  32  architectural HI.
- LO  out  32  architectural LO.

## Operation
- States: IDLE, BUSY. cnt is a down-counter; width must hold max(MULT_CYCLES, DIV_CYCLES).
- start = (op ∈ {1,2,3,4,9–12}) && !req && state==IDLE.
- On a start edge:
  - result computed from operands, latched into pend_hi/pend_lo;
  - cnt ← N−1 (N = MULT_CYCLES or DIV_CYCLES);
  - state ← BUSY.
- BUSY:
  - cnt≠0: cnt decrements.
  - cnt==0: HI←pend_hi, LO←pend_lo, state←IDLE.
- Arithmetic:
  - mult: signed 32×32→64, {HI,LO}=product.
  - multu: unsigned 32×32→64, {HI,LO}=product.
  - div: LO=quotient, HI=remainder; truncate toward zero; remainder takes the dividend's sign.
  - divu: unsigned quotient/remainder.
  - 0x80000000 div 0xFFFFFFFF → LO=0x80000000, HI=0.
  - Divisor 0 (div/divu): full busy period elapses; HI/LO unchanged.
- mthi/mtlo: when state==IDLE && !req, HI (or LO) ← E_rs_val at posedge, no busy. When BUSY or req, ignored.
- E_mdu_rd is combinational from current HI/LO, not pending values.
- Ops arriving in E while BUSY are ignored. The hazard unit guarantees none arrive there; the bench flags violations.
- req high while BUSY: the in-flight operation belongs to an older instruction and completes normally.
- Reset asserted (any time, including mid-operation):
  - HI=0, LO=0, pend=0;
  - state IDLE, cnt 0;
  - E_mdu_busy=0, E_mdu_rd=0.
  - The in-flight operation is aborted.

## Timing
- mult/div op in E during cycle t (start=1): E_mdu_busy=1 in cycle t (combinational).
- BUSY for cycles t+1 … t+N; E_mdu_busy=1 throughout.
- New HI/LO visible from cycle t+N+1, when E_mdu_busy=0.
- Back-to-back: the next MDU op may start in cycle t+N+1.
- mthi/mtlo in cycle t: new value visible at t+1.
- mfhi/mflo: zero latency.

## Configuration
- MDU_MADD_EN defined:
  - codes 9–12 are active with MULT_CYCLES latency;
  - madd: {HI,LO} ← {HI,LO} + signed product;
  - maddu: {HI,LO} ← {HI,LO} + unsigned product;
  - msub/msubu: {HI,LO} ← {HI,LO} − product, same signedness rules.
  - Accumulation uses HI/LO at the start edge; 64-bit wrap-around.
- MDU_MADD_EN undefined: codes 9–12 behave as none (no busy, no state change).

## Test plan
- mult rs=0xFFFFFFFE, rt=3: busy high 6 cycles (start + 5); then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- divu 7/2 → after 10 BUSY cycles LO=3, HI=1. div 0xFFFFFFF9/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. div by 0 after mthi 0x11/mtlo 0x22 → HI=0x11, LO=0x22 after 10 cycles.
- mult with req=1 in the same cycle: busy stays 0; HI/LO unchanged. mthi with req=1: HI unchanged.
- reset driven low at BUSY cycle 3 of a div: HI=LO=0 and busy=0 immediately. After release, mfhi returns 0.
- With MDU_MADD_EN, HI=0, LO=0xFFFFFFFF, madd 1×1: after 5 cycles HI=1, LO=0. Without the macro: no busy, values unchanged.
- mflo during BUSY returns the old LO, not the pending result.
